// File: rtl/txt_reg_slave.sv
// txt_reg_slave: register-bus slave of the VGA text controller.
// It accepts one host access per strobe and executes it against the cursor
// state and the character video RAM. o_ready_h reports the idle state back
// to the host.
module txt_reg_slave #(
    parameter int CELLS = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_cmd,
    input  logic [10:0] i_cursor_adr,
    input  logic [7:0]  i_port,
    input  logic        i_cs_h,
    input  logic        i_rl_wh,
    output logic        o_ready_h,
    output logic [7:0]  o_data,
    output logic [10:0] o_vram_adr,
    output logic [7:0]  o_vram_wdata,
    output logic        o_vram_we,
    input  logic [7:0]  i_vram_rdata,
    output logic [10:0] o_cursor_pos,
    output logic        o_cursor_en
);

    localparam logic [7:0]  CMD_STATUS  = 8'h00;
    localparam logic [7:0]  CMD_DATA    = 8'h01;
    localparam logic [7:0]  CMD_CUR_AL  = 8'h02;
    localparam logic [7:0]  CMD_CUR_AH  = 8'h03;
    localparam logic [7:0]  CMD_CONTROL = 8'h04;

    localparam logic [11:0] CELLS_W   = 12'(CELLS);
    localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RD_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;

    // Access captured at the strobe, held stable for the whole access.
    logic [7:0]  cmd_q;
    logic        rw_q;
    logic [7:0]  port_q;
    logic [10:0] adr_q;

    // Architectural state visible to the host.
    logic [10:0] cursor;
    logic        cursor_en;
    logic        wrapped;
    logic [7:0]  data_q;

    logic        is_data_wr;
    logic        is_data_rd;

    assign is_data_wr = rw_q && (cmd_q == CMD_DATA);
    assign is_data_rd = !rw_q && (cmd_q == CMD_DATA);

    // Cursor loads that land outside the screen snap back to cell 0.
    function automatic logic [10:0] clamp_cell(input logic [10:0] v);
        return ({1'b0, v} >= CELLS_W) ? 11'd0 : v;
    endfunction

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the strobe is looked at only while idle.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:    if (i_cs_h) state_next = S_EXEC;
            S_EXEC:    state_next = is_data_rd ? S_RD_WAIT : S_IDLE;
            S_RD_WAIT: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready while idle, a write pulse in EXEC of a DATA write.
    // The write is suppressed when reset arrives in that cycle.
    always_comb begin
        o_ready_h = (state == S_IDLE);
        o_vram_we = (state == S_EXEC) && is_data_wr && !i_rst;
    end

    // Latch the command fields when an access is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q  <= CMD_STATUS;
            rw_q   <= 1'b0;
            port_q <= 8'h00;
            adr_q  <= 11'd0;
        end else if (state == S_IDLE && i_cs_h) begin
            cmd_q  <= i_cmd;
            rw_q   <= i_rl_wh;
            port_q <= i_port;
            adr_q  <= i_cursor_adr;
        end
    end

    // Execute the access: update the cursor and flags, or produce read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cursor    <= 11'd0;
            cursor_en <= 1'b1;
            wrapped   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            case (state)
                S_EXEC: begin
                    if (rw_q) begin
                        case (cmd_q)
                            CMD_DATA: begin
                                if (cursor == LAST_CELL) begin
                                    cursor  <= 11'd0;
                                    wrapped <= 1'b1;
                                end else begin
                                    cursor <= cursor + 11'd1;
                                end
                            end
                            CMD_CUR_AL:  cursor    <= clamp_cell({cursor[10:8], port_q});
                            CMD_CUR_AH:  cursor    <= clamp_cell(adr_q);
                            CMD_CONTROL: cursor_en <= port_q[0];
                            default: ;
                        endcase
                    end else begin
                        case (cmd_q)
                            CMD_STATUS: begin
                                data_q  <= {5'b0, wrapped, cursor_en, 1'b1};
                                wrapped <= 1'b0;
                            end
                            // DATA read data arrives from the RAM next cycle.
                            CMD_DATA:    ;
                            CMD_CUR_AL:  data_q <= cursor[7:0];
                            CMD_CUR_AH:  data_q <= {5'b0, cursor[10:8]};
                            CMD_CONTROL: data_q <= {7'b0, cursor_en};
                            default:     data_q <= 8'h00;
                        endcase
                    end
                end
                S_RD_WAIT: data_q <= i_vram_rdata;
                default: ;
            endcase
        end
    end

    // The RAM always addresses the cursor cell; write data is the latched port.
    assign o_vram_adr   = cursor;
    assign o_vram_wdata = port_q;
    assign o_data       = data_q;
    assign o_cursor_pos = cursor;
    assign o_cursor_en  = cursor_en;

endmodule

// File: tb/tb_txt_reg_slave.sv
// tb_txt_reg_slave: randomized host accesses compared each cycle against a
// transaction-level model of the register slave, with a bench-side video RAM.
module tb_txt_reg_slave;

    localparam int CELLS = 2000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_cmd;
    logic [10:0] i_cursor_adr;
    logic [7:0]  i_port;
    logic        i_cs_h;
    logic        i_rl_wh;
    logic        o_ready_h;
    logic [7:0]  o_data;
    logic [10:0] o_vram_adr;
    logic [7:0]  o_vram_wdata;
    logic        o_vram_we;
    logic [7:0]  i_vram_rdata;
    logic [10:0] o_cursor_pos;
    logic        o_cursor_en;

    always #5 clk = ~clk;

    txt_reg_slave #(.CELLS(CELLS)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cmd        (i_cmd),
        .i_cursor_adr (i_cursor_adr),
        .i_port       (i_port),
        .i_cs_h       (i_cs_h),
        .i_rl_wh      (i_rl_wh),
        .o_ready_h    (o_ready_h),
        .o_data       (o_data),
        .o_vram_adr   (o_vram_adr),
        .o_vram_wdata (o_vram_wdata),
        .o_vram_we    (o_vram_we),
        .i_vram_rdata (i_vram_rdata),
        .o_cursor_pos (o_cursor_pos),
        .o_cursor_en  (o_cursor_en)
    );

    // Bench video RAM: synchronous write, one-cycle registered read.
    bit [7:0] ram [0:2047];
    always @(posedge clk) begin
        if (o_vram_we === 1'b1) ram[o_vram_adr] <= o_vram_wdata;
        i_vram_rdata <= ram[o_vram_adr];
    end

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0]  m_mem [0:2047];
    int        m_cur;
    int        m_en;
    int        m_wrap;
    bit        exp_ready;
    bit        exp_we;
    bit [7:0]  exp_wdata;
    bit        chk_adr;
    int        exp_adr;
    bit [7:0]  exp_data;
    bit        chk_en = 1'b0;
    int        p_cmd, p_rw, p_port, p_adr;

    task automatic model_reset();
        m_cur = 0; m_en = 1; m_wrap = 0;
        exp_ready = 1; exp_we = 0; exp_wdata = 0; chk_adr = 0; exp_data = 0;
    endtask

    // Called right after the edge that accepted the access.
    task automatic begin_acc(input int cmd, input int rw, input int port, input int adr);
        p_cmd = cmd; p_rw = rw; p_port = port; p_adr = adr;
        exp_ready = 0;
        if (cmd == 1) begin
            chk_adr = 1;
            exp_adr = m_cur;
            if (rw != 0) begin
                exp_we = 1;
                exp_wdata = 8'(port);
            end
        end
    endtask

    // Called right after the edge that ends the execute cycle.
    task automatic end_acc();
        int v;
        exp_we = 0; chk_adr = 0; exp_ready = 1;
        if (p_rw != 0) begin
            case (p_cmd)
                1: begin
                    m_mem[m_cur] = 8'(p_port);
                    if (m_cur == CELLS - 1) begin m_cur = 0; m_wrap = 1; end
                    else m_cur = m_cur + 1;
                end
                2: begin
                    v = (m_cur / 256) * 256 + p_port;
                    m_cur = (v >= CELLS) ? 0 : v;
                end
                3: m_cur = (p_adr >= CELLS) ? 0 : p_adr;
                4: m_en = p_port % 2;
                default: ;
            endcase
        end else begin
            case (p_cmd)
                0: begin exp_data = 8'(m_wrap * 4 + m_en * 2 + 1); m_wrap = 0; end
                1: exp_ready = 0;
                2: exp_data = 8'(m_cur % 256);
                3: exp_data = 8'(m_cur / 256);
                4: exp_data = 8'(m_en);
                default: exp_data = 8'h00;
            endcase
        end
    endtask

    task automatic rd_finish();
        exp_data = m_mem[m_cur];
        exp_ready = 1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(o_ready_h), 32'(exp_ready));
            check("vram_we", 32'(o_vram_we), 32'(exp_we));
            check("cursor_pos", 32'(o_cursor_pos), 32'(m_cur));
            check("cursor_en", 32'(o_cursor_en), 32'(m_en));
            check("data", 32'(o_data), 32'(exp_data));
            if (exp_we) check("vram_wdata", 32'(o_vram_wdata), 32'(exp_wdata));
            if (chk_adr) check("vram_adr", 32'(o_vram_adr), 32'(exp_adr));
            if (o_vram_we === 1'b1) we_count++;
        end
    end

    task automatic drive(input int cmd, input int rw, input int port, input int adr);
        i_cmd = 8'(cmd); i_rl_wh = rw[0]; i_port = 8'(port); i_cursor_adr = 11'(adr);
    endtask

    // One host access: strobe for one cycle, then wait out its fixed latency.
    task automatic access(input int cmd, input int rw, input int port, input int adr);
        @(negedge clk);
        drive(cmd, rw, port, adr);
        i_cs_h = 1'b1;
        @(posedge clk); begin_acc(cmd, rw, port, adr);
        @(negedge clk); i_cs_h = 1'b0;
        @(posedge clk); end_acc();
        if (rw == 0 && cmd == 1) begin
            @(posedge clk); rd_finish();
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int c, rw, port, adr, r;
        i_rst = 1'b1; i_cs_h = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        // Strobe during reset must be ignored.
        i_cs_h = 1'b1; drive(1, 1, 8'h99, 0);
        @(posedge clk); #1;
        i_cs_h = 1'b0;
        @(negedge clk); i_rst = 1'b0;
        #1;
        check("rst_ready", 32'(o_ready_h), 32'd1);
        check("rst_cursor", 32'(o_cursor_pos), 32'd0);
        check("rst_en", 32'(o_cursor_en), 32'd1);
        check("rst_we", 32'(o_vram_we), 32'd0);
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_vram_adr", 32'(o_vram_adr), 32'd0);
        check("rst_vram_wdata", 32'(o_vram_wdata), 32'd0);

        // Fill cells 0..255.
        w0 = we_count;
        access(3, 1, 0, 11'h000);
        for (int i = 0; i < 256; i++) access(1, 1, i, 0);
        check("fill_cursor", 32'(o_cursor_pos), 32'd256);
        check("fill_pulses", 32'(we_count - w0), 32'd256);
        for (int i = 0; i < 256; i += 51) check("fill_ram", 32'(ram[i]), 32'(i));
        check("fill_ram_255", 32'(ram[255]), 32'hFF);

        // Wrap at the last cell, sticky flag cleared by STATUS read.
        access(3, 1, 0, 1999);
        access(1, 1, 8'h41, 0);
        check("wrap_ram", 32'(ram[1999]), 32'h41);
        check("wrap_cursor", 32'(o_cursor_pos), 32'd0);
        access(0, 0, 0, 0);
        check("status1", 32'(o_data), 32'h07);
        access(0, 0, 0, 0);
        check("status2", 32'(o_data), 32'h03);

        // Cursor split load and DATA read.
        access(3, 1, 0, 11'h120);
        access(1, 1, 8'h5A, 0);
        access(3, 1, 0, 11'h100);
        access(2, 1, 8'h20, 0);
        check("al_cursor", 32'(o_cursor_pos), 32'h120);
        access(1, 0, 0, 0);
        check("rd_data", 32'(o_data), 32'h5A);
        check("rd_cursor", 32'(o_cursor_pos), 32'h120);
        access(3, 0, 0, 0);
        check("rd_ah", 32'(o_data), 32'h01);

        // CONTROL, unknown command, out-of-range loads.
        access(4, 1, 8'h00, 0);
        check("ctrl_en", 32'(o_cursor_en), 32'd0);
        access(4, 0, 0, 0);
        check("ctrl_rd", 32'(o_data), 32'h00);
        access(7, 1, 8'hFF, 11'h7FF);
        check("unk_cursor", 32'(o_cursor_pos), 32'h120);
        check("unk_en", 32'(o_cursor_en), 32'd0);
        access(3, 1, 0, 2047);
        check("ah_oor", 32'(o_cursor_pos), 32'd0);
        access(3, 1, 0, 11'h700);
        access(2, 1, 8'hFF, 0);
        check("al_oor", 32'(o_cursor_pos), 32'd0);
        access(3, 1, 0, 11'h120);

        // Reset during RD_WAIT aborts the read.
        @(negedge clk); drive(1, 0, 0, 0); i_cs_h = 1'b1;
        @(posedge clk); begin_acc(1, 0, 0, 0);
        @(negedge clk); i_cs_h = 1'b0;
        @(posedge clk); end_acc();
        @(negedge clk); i_rst = 1'b1;
        @(posedge clk); model_reset();
        #1; i_rst = 1'b0;
        check("rdrst_data", 32'(o_data), 32'h00);
        check("rdrst_ready", 32'(o_ready_h), 32'd1);
        check("rdrst_cursor", 32'(o_cursor_pos), 32'd0);
        check("rdrst_en", 32'(o_cursor_en), 32'd1);

        // Reset during EXEC of a DATA write suppresses the write.
        @(negedge clk); drive(1, 1, 8'hEE, 0); i_cs_h = 1'b1;
        @(posedge clk); begin_acc(1, 1, 8'hEE, 0);
        #2; i_rst = 1'b1; exp_we = 0; chk_adr = 0;
        @(negedge clk); i_cs_h = 1'b0;
        @(posedge clk); model_reset();
        #1; i_rst = 1'b0;
        @(posedge clk); #1;
        check("wrrst_ram", 32'(ram[0]), 32'h00);

        // Strobe held three cycles: exactly two accesses.
        w0 = we_count;
        @(negedge clk); drive(1, 1, 8'h77, 0); i_cs_h = 1'b1;
        @(posedge clk); begin_acc(1, 1, 8'h77, 0);
        @(posedge clk); end_acc();
        @(posedge clk); begin_acc(1, 1, 8'h77, 0);
        @(negedge clk); i_cs_h = 1'b0;
        @(posedge clk); end_acc();
        #1;
        @(posedge clk); #1;
        check("hold_cursor", 32'(o_cursor_pos), 32'd2);
        check("hold_pulses", 32'(we_count - w0), 32'd2);
        check("hold_ram1", 32'(ram[1]), 32'h77);

        // Randomized accesses.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            rw = int'($urandom_range(0, 1));
            port = int'($urandom_range(0, 255));
            adr = int'($urandom_range(0, 2047));
            case (r)
                5, 6: c = 1;
                7: begin c = 3; rw = 1; adr = int'($urandom_range(1990, 2047)); end
                8: c = int'($urandom_range(5, 255));
                9: c = 0;
                default: c = r;
            endcase
            access(c, rw, port, adr);
        end

        for (int i = 0; i < CELLS; i++) check("ram_final", 32'(ram[i]), 32'(m_mem[i]));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/txt_reg_slave.md
# txt_reg_slave

Register-bus slave of the VGA text controller: consumes the host command bus (register select, cursor address, data port, chip-select strobe, read/write flag), executes each access against the cursor and video RAM, and signals completion on a ready line. Sits directly between any host/driver (test driver, MCU bridge) and the character video RAM and cursor logic of the display pipeline.

## Interface
- CELLS, 2000: number of character cells (80x25); valid cursor range 0..CELLS-1, CELLS ≤ 2048
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_cmd  in  8  register select: 0x00 STATUS, 0x01 DATA, 0x02 CUR_AL, 0x03 CUR_AH, 0x04 CONTROL
- i_cursor_adr  in  11  cursor address, used by CUR_AH write
- i_port  in  8  write data
- i_cs_h  in  1  access strobe, active-high, one or more cycles
- i_rl_wh  in  1  0 = read, 1 = write; sampled with i_cs_h
- o_ready_h  out  1  1 = idle, access accepted/complete
- o_data  out  8  read data, valid when o_ready_h returns high after a read
- o_vram_adr  out  11  video RAM address
- o_vram_wdata  out  8  video RAM write data
- o_vram_we  out  1  video RAM write enable, single-cycle pulse
- i_vram_rdata  in  8  video RAM read data, 1-cycle latency after o_vram_adr
- o_cursor_pos  out  11  current cursor cell
- o_cursor_en  out  1  cursor display enable

## Operation
- FSM states: IDLE, EXEC, RD_WAIT. IDLE: o_ready_h=1; i_cs_h=1 latches i_cmd, i_rl_wh, i_port, i_cursor_adr → EXEC, o_ready_h=0.
- EXEC write actions:
  - DATA: o_vram_adr=cursor, o_vram_wdata=port, o_vram_we=1 for this cycle; cursor+1, CELLS-1 wraps to 0 and sets sticky `wrapped`.
  - CUR_AL: cursor[7:0]=port; cursor[10:8] kept.
  - CUR_AH: cursor=i_cursor_adr.
  - CONTROL: cursor_en=port[0].
  - STATUS or unknown cmd: no effect.
  - → IDLE.
- Cursor loads (CUR_AL, CUR_AH) with result ≥ CELLS: cursor=0; wrapped unchanged.
- EXEC read actions:
  - DATA: o_vram_adr=cursor → RD_WAIT; RD_WAIT captures i_vram_rdata into o_data → IDLE. Cursor not advanced.
  - STATUS: o_data={5'b0, wrapped, cursor_en, 1'b1}; clears wrapped → IDLE.
  - CUR_AL: o_data=cursor[7:0].
  - CUR_AH: o_data={5'b0, cursor[10:8]}.
  - CONTROL: o_data={7'b0, cursor_en}.
  - Unknown: o_data=0x00.
- o_data holds its value until the next read completes.
- o_cursor_pos, o_cursor_en are registered state, updated at the end of EXEC.

## Timing
- Reset values: o_ready_h=1, o_data=0x00, o_vram_adr=0, o_vram_wdata=0, o_vram_we=0, o_cursor_pos=0, o_cursor_en=1, wrapped=0, state IDLE.
- Reset dominates: i_cs_h in a reset cycle is ignored; reset during EXEC/RD_WAIT aborts the access with no VRAM write.
- Access sampled at edge N (IDLE, i_cs_h=1): o_ready_h=0 from N+1.
- Writes and non-DATA reads: o_vram_we pulse (DATA write) during N+1; o_ready_h=1 and state updated from N+2.
- DATA read: o_vram_adr valid N+1; o_data valid and o_ready_h=1 from N+3.
- Strobe is level-sampled only in IDLE: i_cs_h still high when IDLE is re-entered starts a new access. Hosts drop i_cs_h one cycle after raising it. i_cs_h while busy is ignored; no queueing.
- Back-to-back DATA writes: at most one per 2 cycles.

## Test plan
- Reset, then idle: o_ready_h=1, o_cursor_pos=0, o_cursor_en=1, o_vram_we=0, o_data=0x00.
- CUR_AH write with i_cursor_adr=0x000, then 256 DATA writes of 0x00..0xFF with ready handshake: VRAM cells 0..255 = 0x00..0xFF; one o_vram_we pulse per write; o_cursor_pos=256.
- CUR_AH write 1999, DATA write 0x41: cell 1999=0x41; cursor=0. STATUS read: o_data=0x07. Second STATUS read: o_data=0x03.
- CUR_AH write 0x100, CUR_AL write 0x20: cursor=0x120. DATA read with VRAM[0x120]=0x5A: o_data=0x5A at N+3; cursor stays 0x120.
- CONTROL write port=0x00: o_cursor_en=0. CONTROL read: o_data=0x00. Unknown cmd 0x07 write: no state change; ready back at N+2.
- i_cs_h held 3 cycles: exactly two accesses, at N and N+2; i_rst asserted during RD_WAIT: no capture, all outputs at reset values next cycle.
